// File: rtl/nn_batch_validator_if.sv
// Signal bundle for nn_batch_validator: run control, sample-memory read port,
// nn-core handshake and result outputs.
// Optional macro NN_VAL_TIMEOUT_EN adds the sticky timeout flag.
interface nn_batch_validator_if #(
    parameter int NI = 256,
    parameter int NC = 10,
    parameter int N  = 319
);
    localparam int CW = $clog2(NC);
    localparam int AW = $clog2(N);
    localparam int KW = $clog2(N + 1);

    logic          go;
    logic          mode;
    logic [AW-1:0] sel;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [NI-1:0] mem_xi;
    logic [CW-1:0] mem_lbl;
    logic [NI-1:0] xi;
    logic          start;
    logic          ack;
    logic          done;
    logic [CW-1:0] yi;
    logic          busy;
    logic          finished;
    logic          pass;
    logic [KW-1:0] correct;
    logic [KW-1:0] total;
`ifdef NN_VAL_TIMEOUT_EN
    logic          timeout;
`endif

    // Validator side: consumes requests, memory data and core responses
    modport master (
        input  go, mode, sel, mem_xi, mem_lbl, ack, done, yi,
        output mem_rd, mem_addr, xi, start, busy, finished, pass, correct, total
`ifdef NN_VAL_TIMEOUT_EN
        , output timeout
`endif
    );

    // Environment side: requester, sample memory and nn core
    modport slave (
        output go, mode, sel, mem_xi, mem_lbl, ack, done, yi,
        input  mem_rd, mem_addr, xi, start, busy, finished, pass, correct, total
`ifdef NN_VAL_TIMEOUT_EN
        , input timeout
`endif
    );
endinterface

// File: rtl/nn_batch_validator.sv
// nn_batch_validator: walks stored samples (all of them, or one selected
// sample), feeds each vector to an nn core, compares the predicted class with
// the stored label and accumulates match / completed-sample counts.
// Optional macro NN_VAL_TIMEOUT_EN adds a 16-bit watchdog over the core
// handshake; an expired watchdog scores the sample as a mismatch.
module nn_batch_validator #(
    parameter int NI = 256,
    parameter int NC = 10,
    parameter int N  = 319
) (
    input  logic                 clk,
    input  logic                 rst,
    nn_batch_validator_if.master bus
);
    localparam int CW = $clog2(NC);
    localparam int AW = $clog2(N);
    localparam int KW = $clog2(N + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [KW-1:0] N_CNT    = KW'(N);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LOAD      = 3'd2,
        START     = 3'd3,
        WAIT_DONE = 3'd4,
        CHECK     = 3'd5,
        FINISH    = 3'd6
    } state_t;

    // Counter increment that holds at N instead of wrapping
    function automatic logic [KW-1:0] sat_inc(input logic [KW-1:0] v);
        logic [KW-1:0] r;
        if (v < N_CNT) begin
            r = v + KW'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [NI-1:0] xi_q, xi_d;
    logic [CW-1:0] lbl_q, lbl_d;
    logic [CW-1:0] yi_q, yi_d;
    logic [KW-1:0] correct_q, correct_d;
    logic [KW-1:0] total_q, total_d;
    logic          pass_q, pass_d;
    logic          finished_q, finished_d;
    logic          start_q, start_d;
    logic          mem_rd_q, mem_rd_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] sel_clamp_s;
    logic          match_s;

`ifdef NN_VAL_TIMEOUT_EN
    logic [15:0]   wdog_q, wdog_d;
    logic [15:0]   wdog_inc_s;
    logic          wdog_exp_s;
    logic          tmo_q, tmo_d;
    logic          timeout_q, timeout_d;

    // Watchdog counts handshake cycles, saturating, and clears elsewhere
    always_comb begin
        if (wdog_q == 16'hFFFF) begin
            wdog_inc_s = 16'hFFFF;
        end else begin
            wdog_inc_s = wdog_q + 16'd1;
        end
        if ((state_q == START) || (state_q == WAIT_DONE)) begin
            wdog_d = wdog_inc_s;
        end else begin
            wdog_d = 16'd0;
        end
        wdog_exp_s = (wdog_inc_s == 16'hFFFF);
    end

    // Watchdog, per-sample timeout mark and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q    <= 16'd0;
            tmo_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`endif

    // Out-of-range single-mode index falls back to the last sample
    always_comb begin
        if (KW'(bus.sel) >= N_CNT) begin
            sel_clamp_s = LAST_IDX;
        end else begin
            sel_clamp_s = bus.sel;
        end
    end

    // Prediction matches label; a timed-out sample never matches
    always_comb begin
`ifdef NN_VAL_TIMEOUT_EN
        match_s = (yi_q == lbl_q) && !tmo_q;
`else
        match_s = (yi_q == lbl_q);
`endif
    end

    // Next-state and datapath update for the run sequencer
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        xi_d       = xi_q;
        lbl_d      = lbl_q;
        yi_d       = yi_q;
        correct_d  = correct_q;
        total_d    = total_q;
        pass_d     = pass_q;
        finished_d = finished_q;
`ifdef NN_VAL_TIMEOUT_EN
        tmo_d      = tmo_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d    = FETCH;
                    mode_d     = bus.mode;
                    correct_d  = '0;
                    total_d    = '0;
                    finished_d = 1'b0;
`ifdef NN_VAL_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                    if (bus.mode) begin
                        idx_d = sel_clamp_s;
                    end else begin
                        idx_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                state_d = LOAD;
`ifdef NN_VAL_TIMEOUT_EN
                tmo_d   = 1'b0;
`endif
            end
            LOAD: begin
                xi_d    = bus.mem_xi;
                lbl_d   = bus.mem_lbl;
                state_d = START;
            end
            START: begin
                // done without ack is a stray pulse and is not taken
                if (bus.ack) begin
                    if (bus.done) begin
                        yi_d    = bus.yi;
                        state_d = CHECK;
                    end else begin
                        state_d = WAIT_DONE;
                    end
                end
`ifdef NN_VAL_TIMEOUT_EN
                else if (wdog_exp_s) begin
                    tmo_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = CHECK;
                end
`endif
                else begin
                    state_d = START;
                end
            end
            WAIT_DONE: begin
                if (bus.done) begin
                    yi_d    = bus.yi;
                    state_d = CHECK;
                end
`ifdef NN_VAL_TIMEOUT_EN
                else if (wdog_exp_s) begin
                    tmo_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = CHECK;
                end
`endif
                else begin
                    state_d = WAIT_DONE;
                end
            end
            CHECK: begin
                total_d = sat_inc(total_q);
                pass_d  = match_s;
                if (match_s) begin
                    correct_d = sat_inc(correct_q);
                end else begin
                    correct_d = correct_q;
                end
                if (mode_q || (idx_q == LAST_IDX)) begin
                    state_d    = FINISH;
                    finished_d = 1'b1;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = FETCH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are registered from the state being entered
    always_comb begin
        start_d  = (state_d == START);
        mem_rd_d = (state_d == FETCH);
        busy_d   = (state_d != IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            idx_q      <= '0;
            xi_q       <= '0;
            lbl_q      <= '0;
            yi_q       <= '0;
            correct_q  <= '0;
            total_q    <= '0;
            pass_q     <= 1'b0;
            finished_q <= 1'b0;
            start_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            xi_q       <= xi_d;
            lbl_q      <= lbl_d;
            yi_q       <= yi_d;
            correct_q  <= correct_d;
            total_q    <= total_d;
            pass_q     <= pass_d;
            finished_q <= finished_d;
            start_q    <= start_d;
            mem_rd_q   <= mem_rd_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = idx_q;
    assign bus.xi       = xi_q;
    assign bus.start    = start_q;
    assign bus.busy     = busy_q;
    assign bus.finished = finished_q;
    assign bus.pass     = pass_q;
    assign bus.correct  = correct_q;
    assign bus.total    = total_q;
endmodule

// File: tb/tb_nn_batch_validator.sv
// Directed bench for nn_batch_validator with N=4 samples, a one-cycle-latency
// sample memory model and a configurable nn-core model.
module tb_nn_batch_validator;
    localparam int NI = 16;
    localparam int NC = 10;
    localparam int N  = 4;
    localparam int CW = 4;
    localparam int AW = 2;
    localparam int KW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nn_batch_validator_if #(.NI(NI), .NC(NC), .N(N)) bus();
    nn_batch_validator #(.NI(NI), .NC(NC), .N(N)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    typedef struct {
        bit            mode;
        logic [AW-1:0] sel;
        logic [15:0]   lbls;
        logic [15:0]   resps;
        int            ack_dly;
        int            done_dly;
        bit            same;
        bit            early;
        int            stray;
        int            exp_c;
        int            exp_t;
        bit            exp_p;
        int            exp_busy;
        int            exp_rd;
        int            exp_a2;
    } vec_t;

    logic [CW-1:0] lbl_tab  [N];
    logic [CW-1:0] resp_tab [N];
    int ack_dly = 1, done_dly = 1;
    bit same_cyc = 1'b0, early_done = 1'b0, never_ack = 1'b0;
    int busy_cyc = 0, rd_cyc = 0, addr2_cyc = 0;
    int run_busy, run_rd, run_a2;
    int checks = 0, failures = 0;

    // Sample memory: data for mem_addr appears the cycle after mem_rd
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_xi  <= NI'(bus.mem_addr);
            bus.mem_lbl <= lbl_tab[bus.mem_addr];
        end
    end

    // Activity monitor sampled on the falling edge
    always @(negedge clk) begin
        if (bus.busy) busy_cyc++;
        if (bus.mem_rd) begin
            rd_cyc++;
            if (bus.mem_addr == 2'd2) addr2_cyc++;
        end
    end

    // nn-core model: ack after ack_dly cycles of start, done after done_dly more
    initial begin
        int  cnt;
        bit  in_wait;
        cnt = 0;
        in_wait = 1'b0;
        bus.ack = 1'b0;
        bus.done = 1'b0;
        bus.yi = '0;
        forever begin
            @(negedge clk);
            bus.ack = 1'b0;
            bus.done = 1'b0;
            if (!rst) begin
                cnt = 0;
                in_wait = 1'b0;
            end else if (in_wait) begin
                cnt++;
                if (cnt >= done_dly) begin
                    bus.done = 1'b1;
                    bus.yi = resp_tab[bus.xi[AW-1:0]];
                    in_wait = 1'b0;
                    cnt = 0;
                end
            end else if (bus.start && !never_ack) begin
                cnt++;
                if (cnt >= ack_dly) begin
                    bus.ack = 1'b1;
                    cnt = 0;
                    if (same_cyc) begin
                        bus.done = 1'b1;
                        bus.yi = resp_tab[bus.xi[AW-1:0]];
                    end else begin
                        in_wait = 1'b1;
                    end
                end else if (early_done) begin
                    bus.done = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_tables(input logic [15:0] lbls, input logic [15:0] resps);
        for (int i = 0; i < N; i++) begin
            lbl_tab[i]  = lbls[4*i +: 4];
            resp_tab[i] = resps[4*i +: 4];
        end
    endtask

    // One run from go to finished; optional ignored go pulse at cycle 'stray'
    task automatic run(input bit m, input logic [AW-1:0] s, input int stray,
                       input int budget, input string tag);
        int b0, r0, a0, n;
        @(negedge clk);
        b0 = busy_cyc;
        r0 = rd_cyc;
        a0 = addr2_cyc;
        bus.go = 1'b1;
        bus.mode = m;
        bus.sel = s;
        @(negedge clk);
        bus.go = 1'b0;
        check({tag, " finished_clears"}, bus.finished, 0);
        n = 0;
        while (!(bus.finished && !bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
            if (stray != 0 && n == stray) begin
                bus.go = 1'b1;
                bus.mode = 1'b1;
                bus.sel = 2'd1;
            end else begin
                bus.go = 1'b0;
            end
        end
        check({tag, " completes"}, (n < budget), 1);
        run_busy = busy_cyc - b0;
        run_rd   = rd_cyc - r0;
        run_a2   = addr2_cyc - a0;
    endtask

    initial begin
        vec_t vecs[8];
        int   n;
        string t;
        vecs[0] = '{1'b0, 2'd0, 16'h9073, 16'h9173, 1, 1, 1'b0, 1'b0, 0, 3, 4, 1'b1, 21, 4, 1};
        vecs[1] = '{1'b1, 2'd2, 16'h9573, 16'h9573, 1, 1, 1'b0, 1'b0, 0, 1, 1, 1'b1,  6, 1, 1};
        vecs[2] = '{1'b1, 2'd2, 16'h9073, 16'h9173, 1, 1, 1'b0, 1'b0, 0, 0, 1, 1'b0,  6, 1, 1};
        vecs[3] = '{1'b1, 2'd0, 16'h9073, 16'h9173, 1, 1, 1'b1, 1'b0, 0, 1, 1, 1'b1,  5, 1, 0};
        vecs[4] = '{1'b0, 2'd0, 16'h9073, 16'h9173, 1, 1, 1'b1, 1'b0, 0, 3, 4, 1'b1, 17, 4, 1};
        vecs[5] = '{1'b1, 2'd3, 16'h9073, 16'h9173, 3, 2, 1'b0, 1'b1, 0, 1, 1, 1'b1,  9, 1, 0};
        vecs[6] = '{1'b0, 2'd0, 16'h9073, 16'h9073, 2, 3, 1'b0, 1'b0, 5, 4, 4, 1'b1, 33, 4, 1};
        vecs[7] = '{1'b0, 2'd0, 16'h9073, 16'h8073, 1, 1, 1'b0, 1'b0, 0, 3, 4, 1'b0, 21, 4, 1};

        bus.go = 1'b0;
        bus.mode = 1'b0;
        bus.sel = '0;
        set_tables(16'h9073, 16'h9173);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset start", bus.start, 0);
        check("reset mem_rd", bus.mem_rd, 0);
        check("reset finished", bus.finished, 0);
        check("reset pass", bus.pass, 0);
        check("reset correct", bus.correct, 0);
        check("reset total", bus.total, 0);
        check("reset mem_addr", bus.mem_addr, 0);
        check("reset xi", bus.xi, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            set_tables(vecs[v].lbls, vecs[v].resps);
            ack_dly = vecs[v].ack_dly;
            done_dly = vecs[v].done_dly;
            same_cyc = vecs[v].same;
            early_done = vecs[v].early;
            t = $sformatf("v%0d", v);
            run(vecs[v].mode, vecs[v].sel, vecs[v].stray, 200, t);
            check({t, " correct"}, bus.correct, vecs[v].exp_c);
            check({t, " total"}, bus.total, vecs[v].exp_t);
            check({t, " pass"}, bus.pass, vecs[v].exp_p);
            check({t, " finished"}, bus.finished, 1);
            check({t, " busy_cycles"}, run_busy, vecs[v].exp_busy);
            check({t, " mem_rd_count"}, run_rd, vecs[v].exp_rd);
            check({t, " addr2_reads"}, run_a2, vecs[v].exp_a2);
        end

        // finished holds while idle
        repeat (3) @(negedge clk);
        check("idle finished_sticky", bus.finished, 1);
        check("idle busy", bus.busy, 0);

        // Reset two cycles after the third CHECK of a batch
        set_tables(16'h9073, 16'h9173);
        ack_dly = 1;
        done_dly = 1;
        same_cyc = 1'b0;
        early_done = 1'b0;
        @(negedge clk);
        bus.go = 1'b1;
        bus.mode = 1'b0;
        @(negedge clk);
        bus.go = 1'b0;
        n = 0;
        while (bus.total != 3'd3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midrst reach_total3", (n < 200), 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst busy", bus.busy, 0);
        check("midrst start", bus.start, 0);
        check("midrst mem_rd", bus.mem_rd, 0);
        check("midrst finished", bus.finished, 0);
        check("midrst pass", bus.pass, 0);
        check("midrst correct", bus.correct, 0);
        check("midrst total", bus.total, 0);
        check("midrst mem_addr", bus.mem_addr, 0);
        check("midrst xi", bus.xi, 0);
        @(negedge clk);
        rst = 1'b1;
        run(1'b0, 2'd0, 0, 200, "after_rst");
        check("after_rst total", bus.total, 4);
        check("after_rst correct", bus.correct, 3);
        check("after_rst mem_rd_count", run_rd, 4);

`ifdef NN_VAL_TIMEOUT_EN
        // Core never acks: watchdog expires after 65535 handshake cycles
        never_ack = 1'b1;
        run(1'b1, 2'd0, 0, 70000, "tmo");
        check("tmo timeout", bus.timeout, 1);
        check("tmo total", bus.total, 1);
        check("tmo correct", bus.correct, 0);
        check("tmo pass", bus.pass, 0);
        check("tmo busy_cycles", run_busy, 65539);
        never_ack = 1'b0;
        run(1'b1, 2'd0, 0, 200, "tmo_clear");
        check("tmo_clear timeout", bus.timeout, 0);
        check("tmo_clear correct", bus.correct, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
